pe_array_stu_arb: RTL

Parametrised upstream Stack Bus concentrator for the PE array. It merges the `pe__stu__*` upstream interfaces of NUM_CH PEs onto one upstream Stack Bus port. Each channel has a small FIFO, and the arbiter is round-robin and packet-atomic. The block also produces the array-wide `sys__pe__allSynchronized` barrier from the per-PE `pe__sys__thisSynchronized` flags. It sits in the PE array between the generated PE instances and the stack upstream interface.

---
 rtl/pe_array_stu_arb_pkg.sv | 29 ++
 rtl/pe_array_stu_fifo.sv | 77 +++++++
 rtl/pe_array_stu_arb.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_array_stu_arb_pkg.sv
// pe_array_stu_arb_pkg: shared definitions for the PE array upstream Stack Bus
// concentrator (cntl encodings, arbiter states, default widths, cntl helpers).
package pe_array_stu_arb_pkg;

  // Stack Bus cntl encodings: bit 0 marks a packet start, bit 1 a packet end.
  localparam logic [1:0] PE_ARRAY_STU_CNTL_MOM     = 2'b00;
  localparam logic [1:0] PE_ARRAY_STU_CNTL_SOM     = 2'b01;
  localparam logic [1:0] PE_ARRAY_STU_CNTL_EOM     = 2'b10;
  localparam logic [1:0] PE_ARRAY_STU_CNTL_SOM_EOM = 2'b11;

  // Arbiter states.
  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Default widths.
  localparam int PE_ARRAY_STU_NUM_CH_DEF     = 16;
  localparam int PE_ARRAY_STU_FIFO_DEPTH_DEF = 4;
  localparam int PE_ARRAY_STU_TYPE_W_DEF     = 2;
  localparam int PE_ARRAY_STU_DATA_W_DEF     = 64;
  localparam int PE_ARRAY_STU_OOB_W_DEF      = 32;

  // True for SOM and SOM_EOM, the two encodings that open a packet.
  function automatic logic cntl_is_start(input logic [1:0] cntl);
    return cntl[0];
  endfunction

endpackage

// File: rtl/pe_array_stu_fifo.sv
// pe_array_stu_fifo: single-channel synchronous FIFO with registered
// full/empty flags and occupancy. full_nxt exposes next-cycle fullness so the
// parent can register its ready without a path from the incoming valid.
module pe_array_stu_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full_nxt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic [PTR_W:0]   count_nxt_s;
  logic             full_r;
  logic             empty_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_push_s = push & ~full_r;
  assign do_pop_s  = pop & ~empty_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign empty     = empty_r;
  assign full_nxt  = (count_nxt_s == FULL_CNT);

  // Next occupancy from this cycle's accepted push/pop.
  always_comb begin
    count_nxt_s = count_r;
    if (do_push_s && !do_pop_s) begin
      count_nxt_s = count_r + 1'b1;
    end else if (!do_push_s && do_pop_s) begin
      count_nxt_s = count_r - 1'b1;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Entry storage; contents are only observed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally modulo DEPTH; flags registered from next occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == FULL_CNT);
      empty_r <= (count_nxt_s == '0);
    end
  end

endmodule

// File: rtl/pe_array_stu_arb.sv
// pe_array_stu_arb: merges NUM_CH per-PE upstream Stack Bus interfaces onto
// one port through per-channel FIFOs and a packet-atomic round-robin arbiter,
// and produces the registered array-wide synchronisation barrier.
// Optional feature: define PE_ARRAY_STU_ARB_OOB_EN to carry OOB data through
// the FIFOs; otherwise arb__stu__oob_data is tied to 0.
module pe_array_stu_arb
  import pe_array_stu_arb_pkg::*;
#(
  parameter int NUM_CH     = PE_ARRAY_STU_NUM_CH_DEF,
  parameter int FIFO_DEPTH = PE_ARRAY_STU_FIFO_DEPTH_DEF,
  parameter int TYPE_W     = PE_ARRAY_STU_TYPE_W_DEF,
  parameter int DATA_W     = PE_ARRAY_STU_DATA_W_DEF,
  parameter int OOB_W      = PE_ARRAY_STU_OOB_W_DEF
) (
  input  logic                        clk,
  input  logic                        reset_poweron,
  input  logic [NUM_CH-1:0]           ch_enable,
  input  logic [NUM_CH-1:0]           pe__stu__valid,
  input  logic [2*NUM_CH-1:0]         pe__stu__cntl,
  output logic [NUM_CH-1:0]           stu__pe__ready,
  input  logic [TYPE_W*NUM_CH-1:0]    pe__stu__type,
  input  logic [DATA_W*NUM_CH-1:0]    pe__stu__data,
  input  logic [OOB_W*NUM_CH-1:0]     pe__stu__oob_data,
  output logic                        arb__stu__valid,
  output logic [1:0]                  arb__stu__cntl,
  input  logic                        stu__arb__ready,
  output logic [TYPE_W-1:0]           arb__stu__type,
  output logic [DATA_W-1:0]           arb__stu__data,
  output logic [OOB_W-1:0]            arb__stu__oob_data,
  output logic [$clog2(NUM_CH)-1:0]   arb__stu__peId,
  input  logic [NUM_CH-1:0]           pe__sys__thisSynchronized,
  output logic                        sys__pe__allSynchronized,
  output logic                        arb__sys__protoErr
);

  localparam int ID_W = $clog2(NUM_CH);
`ifdef PE_ARRAY_STU_ARB_OOB_EN
  localparam int ENTRY_W = 2 + TYPE_W + DATA_W + OOB_W;
`else
  localparam int ENTRY_W = 2 + TYPE_W + DATA_W;
`endif

  logic [ENTRY_W-1:0] head_s [NUM_CH];
  logic [NUM_CH-1:0]  empty_s;
  logic [NUM_CH-1:0]  full_nxt_s;
  logic [NUM_CH-1:0]  push_s;
  logic [NUM_CH-1:0]  pop_s;
  logic [NUM_CH-1:0]  req_s;
  logic [NUM_CH-1:0]  ready_r;

  arb_state_e         state_r;
  logic [ID_W-1:0]    last_grant_r;
  logic [ID_W-1:0]    lock_ch_r;

  logic               out_free_s;
  logic               win_found_s;
  logic [ID_W-1:0]    win_idx_s;
  int                 scan_idx_s;
  logic               pop_en_s;
  logic [ID_W-1:0]    sel_idx_s;
  logic [ENTRY_W-1:0] sel_head_s;
  logic [1:0]         sel_cntl_s;
  logic [TYPE_W-1:0]  sel_type_s;
  logic [DATA_W-1:0]  sel_data_s;

  logic               out_valid_r;
  logic [1:0]         out_cntl_r;
  logic [TYPE_W-1:0]  out_type_r;
  logic [DATA_W-1:0]  out_data_r;
  logic [ID_W-1:0]    out_id_r;
  logic               proto_err_r;
  logic               all_sync_r;

  assign push_s = pe__stu__valid & ready_r;

  // Per-channel FIFOs; each entry is {cntl, type, data[, oob]}.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [ENTRY_W-1:0] wdata_s;
`ifdef PE_ARRAY_STU_ARB_OOB_EN
    assign wdata_s = {pe__stu__cntl[g*2 +: 2], pe__stu__type[g*TYPE_W +: TYPE_W],
                      pe__stu__data[g*DATA_W +: DATA_W], pe__stu__oob_data[g*OOB_W +: OOB_W]};
`else
    assign wdata_s = {pe__stu__cntl[g*2 +: 2], pe__stu__type[g*TYPE_W +: TYPE_W],
                      pe__stu__data[g*DATA_W +: DATA_W]};
`endif
    pe_array_stu_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
    ) u_fifo (
      .clk      (clk),
      .rst_n    (reset_poweron),
      .push     (push_s[g]),
      .pop      (pop_s[g]),
      .wdata    (wdata_s),
      .rdata    (head_s[g]),
      .empty    (empty_s[g]),
      .full_nxt (full_nxt_s[g])
    );
  end

  // Round-robin scan starting after last_grant; disabled channels never request.
  always_comb begin
    req_s       = ch_enable & ~empty_s;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    scan_idx_s  = 0;
    for (int off = 1; off <= NUM_CH; off++) begin
      scan_idx_s = int'(last_grant_r) + off;
      if (scan_idx_s >= NUM_CH) begin
        scan_idx_s = scan_idx_s - NUM_CH;
      end else begin
        scan_idx_s = scan_idx_s;
      end
      if (!win_found_s && req_s[scan_idx_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = scan_idx_s[ID_W-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Pop selection: winner in IDLE, only the locked channel while LOCKED.
  always_comb begin
    out_free_s = ~out_valid_r | stu__arb__ready;
    pop_en_s   = 1'b0;
    sel_idx_s  = win_idx_s;
    pop_s      = '0;
    case (state_r)
      ARB_IDLE: begin
        sel_idx_s = win_idx_s;
        pop_en_s  = out_free_s & win_found_s;
      end
      ARB_LOCKED: begin
        sel_idx_s = lock_ch_r;
        pop_en_s  = out_free_s & ~empty_s[lock_ch_r];
      end
      default: begin
        sel_idx_s = win_idx_s;
        pop_en_s  = 1'b0;
      end
    endcase
    if (pop_en_s) begin
      pop_s[sel_idx_s] = 1'b1;
    end else begin
      pop_s = '0;
    end
  end

  assign sel_head_s = head_s[sel_idx_s];
  assign sel_cntl_s = sel_head_s[ENTRY_W-1 -: 2];
  assign sel_type_s = sel_head_s[ENTRY_W-3 -: TYPE_W];
  assign sel_data_s = sel_head_s[ENTRY_W-3-TYPE_W -: DATA_W];

  // Arbiter FSM: packet lock, round-robin pointer and sticky protocol error.
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      state_r      <= ARB_IDLE;
      last_grant_r <= ID_W'(NUM_CH - 1);
      lock_ch_r    <= '0;
      proto_err_r  <= 1'b0;
    end else if (pop_en_s) begin
      case (state_r)
        ARB_IDLE: begin
          last_grant_r <= sel_idx_s;
          if (sel_cntl_s == PE_ARRAY_STU_CNTL_SOM) begin
            state_r   <= ARB_LOCKED;
            lock_ch_r <= sel_idx_s;
          end else if (sel_cntl_s != PE_ARRAY_STU_CNTL_SOM_EOM) begin
            // Stray MOM/EOM: forwarded as a single-word packet and flagged.
            proto_err_r <= 1'b1;
          end
        end
        ARB_LOCKED: begin
          if (sel_cntl_s == PE_ARRAY_STU_CNTL_EOM) begin
            state_r <= ARB_IDLE;
          end else if (cntl_is_start(sel_cntl_s)) begin
            proto_err_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ARB_IDLE;
        end
      endcase
    end
  end

  // Output register: loaded on pop, held under backpressure, cleared on drain.
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      out_valid_r <= 1'b0;
      out_cntl_r  <= 2'b00;
      out_type_r  <= '0;
      out_data_r  <= '0;
      out_id_r    <= '0;
    end else if (pop_en_s) begin
      out_valid_r <= 1'b1;
      out_cntl_r  <= sel_cntl_s;
      out_type_r  <= sel_type_s;
      out_data_r  <= sel_data_s;
      out_id_r    <= sel_idx_s;
    end else if (stu__arb__ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Registered per-channel ready and array-wide barrier.
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      ready_r    <= '0;
      all_sync_r <= 1'b0;
    end else begin
      ready_r    <= ch_enable & ~full_nxt_s;
      all_sync_r <= &(pe__sys__thisSynchronized | ~ch_enable);
    end
  end

`ifdef PE_ARRAY_STU_ARB_OOB_EN
  logic [OOB_W-1:0] out_oob_r;

  // OOB field travels with its word through the output register.
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      out_oob_r <= '0;
    end else if (pop_en_s) begin
      out_oob_r <= sel_head_s[OOB_W-1:0];
    end
  end

  assign arb__stu__oob_data = out_oob_r;
`else
  logic oob_unused_s;
  assign oob_unused_s       = ^pe__stu__oob_data;
  assign arb__stu__oob_data = '0;
`endif

  assign stu__pe__ready           = ready_r;
  assign arb__stu__valid          = out_valid_r;
  assign arb__stu__cntl           = out_cntl_r;
  assign arb__stu__type           = out_type_r;
  assign arb__stu__data           = out_data_r;
  assign arb__stu__peId           = out_id_r;
  assign sys__pe__allSynchronized = all_sync_r;
  assign arb__sys__protoErr       = proto_err_r;

endmodule
